// File: rtl/iterative_alu.sv
// Iterative ALU: single-cycle logic/arith/shift ops plus a shift-and-add multiplier
// that takes DATA_WIDTH cycles, with valid/ready handshakes on both sides.
module iterative_alu #(
    parameter int DATA_WIDTH = 64,
    parameter bit MUL_ENABLE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            alu_control,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  zero,
    output logic                  illegal,
    output logic                  busy,
    output logic [1:0]            dbg_state
);

    localparam int SHW = $clog2(DATA_WIDTH);
    localparam int CW  = $clog2(DATA_WIDTH) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_ORR  = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_PASS = 4'b0111;
    localparam logic [3:0] ALU_MUL  = 4'b1000;
    localparam logic [3:0] ALU_LSL  = 4'b1001;
    localparam logic [3:0] ALU_LSR  = 4'b1010;

    logic [1:0]            state;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] mcand;
    logic [DATA_WIDTH-1:0] mplier;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  zero_q;
    logic                  illegal_q;

    logic [SHW-1:0]        shamt;
    logic [DATA_WIDTH-1:0] op_result;
    logic                  op_illegal;
    logic                  op_is_mul;
    logic [DATA_WIDTH-1:0] acc_next;

    // Handshake: a transfer happens on a rising edge where valid && ready are both
    // high; in_ready only in IDLE, out_valid only in DONE, and outputs stay frozen
    // in DONE until out_ready is seen.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == MUL);
    assign dbg_state = state;
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

    assign shamt = b[SHW-1:0];

    always_comb begin
        op_result  = '0;
        op_illegal = 1'b0;
        op_is_mul  = 1'b0;
        case (alu_control)
            ALU_AND:  op_result = a & b;
            ALU_ORR:  op_result = a | b;
            ALU_ADD:  op_result = a + b;
            ALU_SUB:  op_result = a - b;
            ALU_PASS: op_result = b;
            ALU_LSL:  op_result = a << shamt;
            ALU_LSR:  op_result = a >> shamt;
            ALU_MUL: begin
                // A disabled multiplier falls back to the illegal-code path.
                if (MUL_ENABLE) op_is_mul  = 1'b1;
                else            op_illegal = 1'b1;
            end
            default:  op_illegal = 1'b1;
        endcase
    end

    assign acc_next = mplier[0] ? (acc + mcand) : acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (op_is_mul) begin
                            mcand  <= a;
                            mplier <= b;
                            acc    <= '0;
                            cnt    <= CW'(DATA_WIDTH);
                            state  <= MUL;
                        end else begin
                            result_q  <= op_result;
                            zero_q    <= (op_result == '0);
                            illegal_q <= op_illegal;
                            state     <= DONE;
                        end
                    end
                end
                MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CW'(1);
                    // Last step: publish the final partial sum directly.
                    if (cnt == CW'(1)) begin
                        result_q  <= acc_next;
                        zero_q    <= (acc_next == '0);
                        illegal_q <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iterative_alu.sv
// Randomized and directed bench for iterative_alu against a plain-arithmetic model;
// a second instance is built with the multiplier disabled.
module tb_iterative_alu;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  alu_control;
  logic [63:0] a, b, result;
  logic        zero, illegal, busy;
  logic [1:0]  dbg_state;

  logic        n_in_valid, n_in_ready, n_out_valid, n_out_ready;
  logic [3:0]  n_alu_control;
  logic [7:0]  n_a, n_b, n_result;
  logic        n_zero, n_illegal, n_busy;
  logic [1:0]  n_dbg_state;

  iterative_alu #(.DATA_WIDTH(64), .MUL_ENABLE(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .illegal(illegal),
    .busy(busy), .dbg_state(dbg_state)
  );

  iterative_alu #(.DATA_WIDTH(8), .MUL_ENABLE(1'b0)) dut_nomul (
    .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready),
    .alu_control(n_alu_control), .a(n_a), .b(n_b), .out_valid(n_out_valid),
    .out_ready(n_out_ready), .result(n_result), .zero(n_zero), .illegal(n_illegal),
    .busy(n_busy), .dbg_state(n_dbg_state)
  );

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];
  logic        exp_ill_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: {illegal, result} straight from the opcode table.
  function automatic logic [64:0] model(input logic [3:0] op, input logic [63:0] x,
                                        input logic [63:0] y, input bit mul_en);
    logic [5:0] sh;
    sh = y[5:0];
    case (op)
      4'b0000: return {1'b0, x & y};
      4'b0001: return {1'b0, x | y};
      4'b0010: return {1'b0, x + y};
      4'b0110: return {1'b0, x - y};
      4'b0111: return {1'b0, y};
      4'b1000: return mul_en ? {1'b0, x * y} : {1'b1, 64'd0};
      4'b1001: return {1'b0, x << sh};
      4'b1010: return {1'b0, x >> sh};
      default: return {1'b1, 64'd0};
    endcase
  endfunction

  // Scoreboard: every completed handshake must match the next expected result.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got result %0h expected no output", result);
      end else begin
        logic [63:0] e;
        logic        il;
        e  = exp_q.pop_front();
        il = exp_ill_q.pop_front();
        check("sb_result", result, e);
        check("sb_zero", 64'(zero), 64'(e == 64'd0));
        check("sb_illegal", 64'(illegal), 64'(il));
      end
    end
  end

  task automatic run_op(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y,
                        input int hold);
    logic [64:0] m;
    int lat, guard, exp_lat;
    bit is_mul;
    is_mul = (op == 4'b1000);
    exp_lat = is_mul ? 65 : 1;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    check("in_ready_idle", 64'(in_ready), 64'd1);
    m = model(op, x, y, 1'b1);
    alu_control = op; a = x; b = y; in_valid = 1'b1;
    exp_q.push_back(m[63:0]);
    exp_ill_q.push_back(m[64]);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    alu_control = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 200) begin
      check("busy_during", 64'(busy), 64'(is_mul));
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    if (!out_valid) begin
      exp_q.delete();
      exp_ill_q.delete();
      return;
    end
    check("busy_done", 64'(busy), 64'd0);
    check("in_ready_done", 64'(in_ready), 64'd0);
    repeat (hold) begin
      in_valid = 1'($urandom_range(0, 1));
      alu_control = 4'($urandom);
      @(posedge clk); #1;
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_result", result, m[63:0]);
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b1;
    alu_control = 4'b0010;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("handshake_valid", 64'(out_valid), 64'd0);
    check("handshake_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [64:0] m;
    logic [3:0]  op;
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; alu_control = 4'd0; a = '0; b = '0;
    n_in_valid = 1'b0; n_out_ready = 1'b1; n_alu_control = 4'd0; n_a = '0; n_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_result", result, 64'd0);
    check("rst_zero", 64'(zero), 64'd0);
    check("rst_illegal", 64'(illegal), 64'd0);

    m = model(4'b0010, 64'd5, 64'd7, 1'b1);         check("pin_add", m, 65'd12);
    m = model(4'b0110, 64'd3, 64'd3, 1'b1);         check("pin_sub0", m, 65'd0);
    m = model(4'b0110, 64'd0, 64'd1, 1'b1);         check("pin_subwrap", m, 65'h0_FFFF_FFFF_FFFF_FFFF);
    m = model(4'b1000, 64'h1_0000_0001, 64'd3, 1'b1); check("pin_mul", m, 65'h3_0000_0003);
    m = model(4'b1000, 64'h8000_0000_0000_0000, 64'd2, 1'b1); check("pin_mulwrap", m, 65'd0);
    m = model(4'b1001, 64'd1, 64'h43, 1'b1);        check("pin_lsl", m, 65'd8);
    m = model(4'b1010, 64'h80, 64'd4, 1'b1);        check("pin_lsr", m, 65'd8);
    m = model(4'b1111, 64'd9, 64'd9, 1'b1);         check("pin_illegal", m, {1'b1, 64'd0});

    run_op(4'b0010, 64'd5, 64'd7, 0);
    run_op(4'b0110, 64'd3, 64'd3, 1);
    run_op(4'b0110, 64'd0, 64'd1, 0);
    run_op(4'b1000, 64'h1_0000_0001, 64'd3, 0);
    run_op(4'b1000, 64'h8000_0000_0000_0000, 64'd2, 2);
    run_op(4'b1001, 64'd1, 64'h43, 0);
    run_op(4'b1010, 64'h80, 64'd4, 0);
    run_op(4'b1111, 64'd123, 64'd456, 0);
    run_op(4'b0001, 64'hF0F0, 64'h0F0F, 5);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) op = 4'b1000;
      else op = 4'($urandom_range(0, 15));
      run_op(op, {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 3));
    end

    // Reset in the middle of a multiply, with a request presented during reset.
    alu_control = 4'b1000; a = 64'd7; b = 64'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    check("mul_busy_c10", 64'(busy), 64'd1);
    rst = 1'b1; in_valid = 1'b1; alu_control = 4'b0010; a = 64'd1; b = 64'd1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_result", result, 64'd0);
    for (int i = 0; i < 70; i++) begin
      check("abort_no_valid", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
    end
    run_op(4'b0010, 64'd1, 64'd1, 0);

    // Multiplier-disabled build treats MUL as illegal, single cycle.
    n_alu_control = 4'b1000; n_a = 8'd3; n_b = 8'd5; n_in_valid = 1'b1;
    @(posedge clk); #1;
    n_in_valid = 1'b0;
    check("nomul_valid", 64'(n_out_valid), 64'd1);
    check("nomul_illegal", 64'(n_illegal), 64'd1);
    check("nomul_result", 64'(n_result), 64'd0);
    check("nomul_zero", 64'(n_zero), 64'd1);
    check("nomul_busy", 64'(n_busy), 64'd0);
    @(posedge clk); #1;
    check("nomul_in_ready", 64'(n_in_ready), 64'd1);

    repeat (2) @(posedge clk);
    #1;
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/iterative_alu.md
ITERATIVE_ALU -- requirements
Module: iterative_alu

Interface
REQ-001 Parameter DATA_WIDTH, default 64: operand and result width; legal values are powers of two, 8 to 64.
REQ-002 Parameter MUL_ENABLE, default 1: 1 enables the multi-cycle ALU_MUL operation; 0 treats ALU_MUL as an illegal code.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  request present on alu_control/a/b.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 alu_control  input  4  operation code.
REQ-008 a  input  DATA_WIDTH  operand A.
REQ-009 b  input  DATA_WIDTH  operand B.
REQ-010 out_valid  output  1  result, zero and illegal are valid.
REQ-011 out_ready  input  1  consumer accepts the result this cycle.
REQ-012 result  output  DATA_WIDTH  registered result.
REQ-013 zero  output  1  result equals 0.
REQ-014 illegal  output  1  the request carried an undefined code.
REQ-015 busy  output  1  a multiply is in progress.

Function
REQ-016 Codes: ALU_AND=0000 gives a&b; ALU_ORR=0001 gives a|b; ALU_ADD=0010 gives a+b; ALU_SUB=0110 gives a-b; ALU_PASS=0111 gives b; ALU_MUL=1000 gives a*b; ALU_LSL=1001 gives a<<b[log2(DATA_WIDTH)-1:0]; ALU_LSR=1010 gives a>>(same shift amount), logical.
REQ-017 ADD, SUB and MUL wrap modulo 2^DATA_WIDTH; MUL returns the low DATA_WIDTH bits of the unsigned product; no carry or overflow output.
REQ-018 Any other code, or ALU_MUL with MUL_ENABLE=0, completes as single-cycle with result=0, zero=1 and illegal=1.
REQ-019 FSM states are IDLE, MUL and DONE.
REQ-020 in_ready = 1 only in IDLE; a request is accepted on an edge where in_valid && in_ready.
REQ-021 IDLE on accepting a single-cycle op: register result/zero/illegal and go to DONE; out_valid is high in the cycle after acceptance.
REQ-022 IDLE on accepting ALU_MUL (enabled): latch a and b, clear the accumulator, load counter=DATA_WIDTH, go to MUL.
REQ-023 MUL, each cycle: add the multiplicand to the accumulator if the multiplier LSB is 1; shift the multiplicand left 1 and the multiplier right 1; decrement the counter.
REQ-024 MUL to DONE on the cycle the counter reaches 0; out_valid is high exactly DATA_WIDTH+1 cycles after acceptance.
REQ-025 busy = 1 exactly while in MUL.
REQ-026 DONE: out_valid=1; result, zero and illegal are held stable until the handshake.
REQ-027 DONE with out_ready=1 returns to IDLE on the next edge: out_valid falls and in_ready rises that cycle; no new request is accepted in the handshake cycle.
REQ-028 out_ready is ignored outside DONE; in_valid and operand changes are ignored outside IDLE.
REQ-029 zero = (result == 0) for every completed op, MUL included.

Reset
REQ-030 While rst=1 at an edge: state=IDLE, counter=0, accumulator=0, result=0, zero=0, illegal=0, out_valid=0, busy=0; in_ready=1 from the cycle after reset.
REQ-031 Reset asserted in MUL or DONE aborts the operation with no out_valid pulse; a request presented with rst=1 is not accepted.

Verification
REQ-032 DATA_WIDTH=64: ADD a=5, b=7 accepted at cycle 0 -> cycle 1 out_valid=1, result=12, zero=0.
REQ-033 SUB a=3, b=3 -> result=0, zero=1; SUB a=0, b=1 -> result=0xFFFF_FFFF_FFFF_FFFF.
REQ-034 MUL a=0x1_0000_0001, b=3 accepted at cycle 0 -> busy high for cycles 1-64, out_valid at cycle 65, result=0x3_0000_0003; MUL a=2^63, b=2 -> result=0, zero=1.
REQ-035 LSL a=1, b=0x43 -> result=8 (shift amount 3); LSR a=0x80, b=4 -> result=8; code 1111 -> illegal=1, result=0, zero=1.
REQ-036 Backpressure: ORR result held with out_ready=0 for 5 cycles -> out_valid and result stable and in_ready=0 throughout; an in_valid pulse during the hold is not accepted.
REQ-037 rst at cycle 10 of a MUL -> no out_valid; the next ADD 1+1 returns 2 with single-cycle latency; MUL_ENABLE=0 build with a MUL request -> illegal=1 at cycle 1.
